// File: rtl/simon_pkg.sv
// Shared definitions for the arrow game: arrow codes, the press-capture FSM
// states and a helper that tells a real arrow from NOTHING.
package simon_pkg;

  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_NONE  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RELEASE,
    ST_WAIT_PRESS,
    ST_DEBOUNCE,
    ST_HOLD
  } capture_state_t;

  // Codes 100..110 are unused and count as NOTHING, so bit 2 alone decides.
  function automatic logic is_arrow(input logic [2:0] code);
    return ~code[2];
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Clear/enable cycle counter; done flags the enabled cycle on whose edge the
// count would reach LIMIT, and the count wraps to zero on that edge.
module cycle_timer #(
  parameter int unsigned LIMIT = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  assign done = enable && (count == W'(LIMIT - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/arrow_press_capture.sv
// Debounces the per-cycle arrow code into one valid/ready press per key press.
// Define PRESS_TIMEOUT_EN to build the armed-window watchdog driving timeout.
module arrow_press_capture
  import simon_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 150000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] direction_in,
  input  logic       arm,
  input  logic       press_ready,
  output logic       press_valid,
  output logic [2:0] press_dir,
  output logic       timeout
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("STABLE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  capture_state_t   state;
  logic [2:0]       candidate;
  logic [CNT_W-1:0] cnt;
  logic             arrow_now;
  logic             match_now;
  logic             press_done;
  logic             expire;
  logic             expire_now;

  assign arrow_now = is_arrow(direction_in);
  assign match_now = (direction_in == candidate);

  // A press completing on this edge beats a watchdog expiry on the same edge.
  assign press_done = arm &&
                      (((state == ST_WAIT_PRESS) && arrow_now && (STABLE_CYCLES == 1)) ||
                       ((state == ST_DEBOUNCE) && match_now && (cnt == CNT_LAST)));
  assign expire_now = expire && arm && !press_done;

`ifdef PRESS_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_enable = (state == ST_WAIT_RELEASE) || (state == ST_WAIT_PRESS) ||
                     (state == ST_DEBOUNCE);
  assign wd_clear  = arm && ((state == ST_IDLE) || ((state == ST_HOLD) && press_ready));

  cycle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .resetn (resetn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .done   (expire)
  );

  always_ff @(posedge clock) begin
    if (!resetn) timeout <= 1'b0;
    else         timeout <= expire_now;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  // NOTE: reset is sampled on the clock edge here, and all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      candidate   <= DIR_NONE;
      cnt         <= '0;
      press_valid <= 1'b0;
      press_dir   <= DIR_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) state <= ST_WAIT_RELEASE;
        end

        ST_WAIT_RELEASE: begin
          if (!arm || expire_now) state <= ST_IDLE;
          else if (!arrow_now)    state <= ST_WAIT_PRESS;
        end

        ST_WAIT_PRESS: begin
          if (!arm || expire_now) begin
            state <= ST_IDLE;
          end else if (arrow_now) begin
            candidate <= direction_in;
            cnt       <= CNT_W'(1);
            if (press_done) begin
              state       <= ST_HOLD;
              press_valid <= 1'b1;
              press_dir   <= direction_in;
            end else begin
              state <= ST_DEBOUNCE;
            end
          end
        end

        ST_DEBOUNCE: begin
          if (!arm || expire_now) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (!match_now) begin
            // The differing sample is dropped; WAIT_PRESS re-latches next edge.
            state <= ST_WAIT_PRESS;
            cnt   <= '0;
          end else if (press_done) begin
            state       <= ST_HOLD;
            cnt         <= '0;
            press_valid <= 1'b1;
            press_dir   <= candidate;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_HOLD: begin
          if (press_ready) begin
            press_valid <= 1'b0;
            press_dir   <= DIR_NONE;
            state       <= arm ? ST_WAIT_RELEASE : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arrow_press_capture.sv
// Randomised scoreboard bench for arrow_press_capture: a run-length reference
// model predicts press/timeout events, a monitor pops and compares them.
module tb_arrow_press_capture;

  localparam int unsigned STABLE = 4;
`ifdef PRESS_TIMEOUT_EN
  localparam int unsigned TIMEOUT    = 10;
  localparam bit          TIMEOUT_ON = 1'b1;
`else
  localparam int unsigned TIMEOUT    = 1000;
  localparam bit          TIMEOUT_ON = 1'b0;
`endif
  localparam logic [2:0] NONE = 3'b111;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       arm = 1'b0;
  logic       press_ready = 1'b0;
  logic [2:0] direction_in = NONE;
  logic       press_valid;
  logic [2:0] press_dir;
  logic       timeout;

  always #5 clock = ~clock;

  arrow_press_capture #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .direction_in (direction_in),
    .arm          (arm),
    .press_ready  (press_ready),
    .press_valid  (press_valid),
    .press_dir    (press_dir),
    .timeout      (timeout)
  );

  typedef enum int {EV_RISE, EV_FALL, EV_TIMEOUT} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    int         at;
    logic [2:0] dir;
  } ev_t;

  ev_t expq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  edge_no  = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edge_no);
    end
  endtask

  // Reference model: a round is open while armed; after a release it counts
  // the run of identical arrow samples and emits a press once the run hits STABLE.
  bit         m_round = 1'b0;
  bit         m_need_release = 1'b0;
  bit         m_holding = 1'b0;
  logic [2:0] m_run_dir = NONE;
  int         m_run_len = 0;
  int         m_watch = 0;

  function automatic bit arrow(input logic [2:0] d);
    return d inside {3'b000, 3'b001, 3'b010, 3'b011};
  endfunction

  task automatic model_edge(input int at, input logic rn, input logic a,
                            input logic [2:0] d, input logic r);
    if (!rn) begin
      if (m_holding) expq.push_back('{EV_FALL, at, NONE});
      m_round = 0; m_need_release = 0; m_holding = 0; m_run_len = 0; m_watch = 0;
      return;
    end
    if (m_holding) begin
      if (r) begin
        expq.push_back('{EV_FALL, at, NONE});
        m_holding = 0; m_round = a; m_need_release = a; m_run_len = 0; m_watch = 0;
      end
      return;
    end
    if (!m_round) begin
      if (a) begin
        m_round = 1; m_need_release = 1; m_run_len = 0; m_watch = 0;
      end
      return;
    end
    if (!a) begin
      m_round = 0; m_run_len = 0;
      return;
    end
    if (m_need_release)         m_need_release = arrow(d);
    else if (!arrow(d))         m_run_len = 0;
    else if (m_run_len == 0)    begin m_run_dir = d; m_run_len = 1; end
    else if (d == m_run_dir)    m_run_len++;
    else                        m_run_len = 0;
    if (m_run_len == int'(STABLE)) begin
      expq.push_back('{EV_RISE, at, m_run_dir});
      m_holding = 1; m_run_len = 0;
      return;
    end
    m_watch++;
    if (TIMEOUT_ON && m_watch == int'(TIMEOUT)) begin
      expq.push_back('{EV_TIMEOUT, at, NONE});
      m_round = 0; m_run_len = 0;
    end
  endtask

  task automatic step(input logic rn, input logic a, input logic [2:0] d, input logic r);
    @(negedge clock);
    resetn = rn; arm = a; direction_in = d; press_ready = r;
    model_edge(edge_no + 1, rn, a, d, r);
  endtask

  task automatic run(input int n, input logic a, input logic [2:0] d, input logic r);
    for (int i = 0; i < n; i++) step(1'b1, a, d, r);
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, NONE, 1'b0);
    @(posedge clock);
    #1;
    check({tag, "_valid"},   32'(press_valid), 32'(1'b0));
    check({tag, "_dir"},     32'(press_dir),   32'(NONE));
    check({tag, "_timeout"}, 32'(timeout),     32'(1'b0));
  endtask

  task automatic expect_event(input ev_kind_e k, input logic [2:0] d);
    ev_t e;
    if (expq.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got %s at edge %0d, expected none", k.name(), edge_no);
      return;
    end
    e = expq.pop_front();
    check("event_kind", 32'(k), 32'(e.kind));
    check("event_edge", 32'(edge_no), 32'(e.at));
    if (k == EV_RISE) check("press_dir", 32'(d), 32'(e.dir));
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  logic       prev_valid = 1'b0;
  logic [2:0] held_dir = NONE;

  initial begin
    forever begin
      @(posedge clock);
      edge_no++;
      #1;
      if (press_valid !== prev_valid) expect_event(press_valid === 1'b1 ? EV_RISE : EV_FALL, press_dir);
      if (timeout !== 1'b0) expect_event(EV_TIMEOUT, NONE);
      if (press_valid === 1'b1) begin
        if (prev_valid === 1'b1) check("press_dir_stable", 32'(press_dir), 32'(held_dir));
        else held_dir = press_dir;
      end else begin
        check("press_dir_idle", 32'(press_dir), 32'(NONE));
      end
      prev_valid = press_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got no finish, expected finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [2:0] d;
    logic       a;
    int         v;

    do_reset("reset");

    // Clean press of DOWN with ready already high.
    run(2, 1'b1, NONE, 1'b1);
    run(4, 1'b1, 3'b010, 1'b1);
    run(2, 1'b1, NONE, 1'b1);

    // Bounce, then a clean run of RIGHT.
    run(2, 1'b1, 3'b001, 1'b1);
    run(1, 1'b1, NONE, 1'b1);
    run(4, 1'b1, 3'b001, 1'b1);
    run(2, 1'b1, NONE, 1'b1);

    // Held key must not repeat until released.
    run(4, 1'b1, 3'b011, 1'b1);
    run(50, 1'b1, 3'b011, 1'b1);
    run(1, 1'b1, NONE, 1'b1);
    run(4, 1'b1, 3'b011, 1'b1);
    run(2, 1'b1, NONE, 1'b1);

    // Arm rises while UP is already held.
    run(3, 1'b0, NONE, 1'b1);
    run(10, 1'b1, 3'b000, 1'b1);
    run(1, 1'b1, NONE, 1'b1);
    run(4, 1'b1, 3'b000, 1'b1);
    run(2, 1'b1, NONE, 1'b1);

    // Backpressure with arm dropped and input churning.
    run(4, 1'b1, 3'b010, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 3'($urandom_range(7)), 1'b0);
    run(1, 1'b0, NONE, 1'b1);
    run(3, 1'b0, NONE, 1'b0);

    // Armed window with no key at all.
    run(16, 1'b1, NONE, 1'b0);
    run(2, 1'b0, NONE, 1'b0);

    // Reset mid-debounce, then reset while a press is held.
    run(2, 1'b1, NONE, 1'b0);
    run(2, 1'b1, 3'b001, 1'b0);
    do_reset("reset_debounce");
    run(2, 1'b1, NONE, 1'b0);
    run(7, 1'b1, 3'b011, 1'b0);
    do_reset("reset_hold");

    // Random traffic: sticky direction, random ready, occasional arm drop/reset.
    d = NONE;
    a = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        v = int'($urandom_range(9));
        if (v < 4)      d = 3'(v);
        else if (v < 7) d = NONE;
        else            d = 3'(v - 3);
      end
      if ($urandom_range(40) == 0) a = ~a;
      step(($urandom_range(600) != 0), a, d, 1'($urandom_range(1)));
    end

    run(10, 1'b0, NONE, 1'b1);
    check("events_drained", 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arrow_press_capture.md
# arrow_press_capture

Turns the per-cycle 3-bit arrow code from the key-select stage into discrete, debounced press events for the game controller. While armed, it waits for the arrow code to return to NOTHING and then for a valid arrow. It debounces that arrow and presents exactly one press per physical key press on a valid/ready handshake. An optional watchdog reports when the player fails to press in time.

## Interface
- STABLE_CYCLES, 500000 — consecutive identical samples required to accept a press; must be ≥1 (10 ms at 50 MHz).
- TIMEOUT_CYCLES, 150000000 — armed cycles allowed before a timeout is reported; must be ≥2 (3 s at 50 MHz).
- clock  in  1  sole clock; all logic on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- direction_in  in  3  arrow code: 000 UP, 001 RIGHT, 010 DOWN, 011 LEFT, 111 NOTHING; 100–110 treated as NOTHING.
- arm  in  1  level; high = controller wants one press.
- press_ready  in  1  consumer accepts the press when high with press_valid.
- press_valid  out  1  a debounced press is held on press_dir.
- press_dir  out  3  accepted arrow code; 111 whenever press_valid is low.
- timeout  out  1  one-cycle pulse when the armed window expires.

## Operation
- States: IDLE, WAIT_RELEASE, WAIT_PRESS, DEBOUNCE, HOLD.
- IDLE: arm high → WAIT_RELEASE.
- WAIT_RELEASE: input NOTHING → WAIT_PRESS. A key held from a previous round is never accepted.
- WAIT_PRESS: valid arrow sampled → latch the candidate and set cnt=1.
  - If STABLE_CYCLES==1, go directly to HOLD.
  - Otherwise go to DEBOUNCE.
- DEBOUNCE:
  - Sample equals candidate → cnt+1.
  - When cnt reaches STABLE_CYCLES → HOLD.
  - Any differing sample, including NOTHING or another arrow → WAIT_PRESS with cnt cleared. The new sample is not latched on that edge.
- HOLD:
  - press_valid=1; press_dir=candidate, held stable.
  - press_valid & press_ready → WAIT_RELEASE if arm is high, else IDLE.
- arm low in WAIT_RELEASE, WAIT_PRESS or DEBOUNCE → IDLE on the next edge. arm is ignored in HOLD; a captured press is never dropped.
- Debounce counter width is $clog2(STABLE_CYCLES+1).
- Reset values: state IDLE, press_valid 0, press_dir 111, timeout 0, all counters 0.
- Reset asserted mid-operation: everything returns to reset values on that edge, including any pending press.

## Timing
- Let the first valid-arrow sample be taken at edge E0. press_valid rises after edge E0+STABLE_CYCLES−1, provided all samples E0..E0+STABLE_CYCLES−1 match. Latency is STABLE_CYCLES cycles.
- Handshake: the transfer occurs on the edge where press_valid & press_ready. press_valid is low in the following cycle.
- press_ready high while press_valid is low has no effect.
- Minimum spacing between two accepted presses is STABLE_CYCLES+2 cycles: handshake edge, then a NOTHING sample, then STABLE_CYCLES matching samples.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- PRESS_TIMEOUT_EN defined:
  - The watchdog clears on entry to WAIT_RELEASE from IDLE or HOLD.
  - It increments every cycle in WAIT_RELEASE, WAIT_PRESS and DEBOUNCE.
  - On the edge it would reach TIMEOUT_CYCLES: timeout pulses for one cycle and state → IDLE.
  - If debounce completes on the same edge, the press wins: HOLD is entered and no timeout is raised.
  - The watchdog is frozen in HOLD and IDLE.
- PRESS_TIMEOUT_EN undefined: no watchdog logic is built, and timeout is tied to 0. The port remains present.

## Structure
- Shared package simon_pkg holds:
  - direction localparams DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT, DIR_NONE;
  - the capture state enum;
  - a helper function is_arrow(code).
- One sub-module, cycle_timer: a parameterised clear/enable counter with a terminal pulse. It is instantiated for the watchdog only under PRESS_TIMEOUT_EN.

## Test plan
- STABLE=4, arm=1: input 111, then 010 for 4 cycles → press_valid after the 4th sample, press_dir=010. press_ready=1 → press_valid low the next cycle.
- Bounce: 001 for 2 cycles, 111 for 1, 001 for 4 → exactly one press of 001, valid after the final 4th sample.
- Held key: after a handshake, keep 011 asserted for 50 cycles → no second press. Then 111 followed by 011 for 4 cycles → a second press.
- Arm while key held: arm rises with 000 already present → no press until 111 is seen.
- Backpressure: press_ready=0 for 20 cycles, with arm dropped and input changed → press_valid and press_dir stay stable; transfer completes on the ready edge; state → IDLE.
- PRESS_TIMEOUT_EN, TIMEOUT=10: arm with input 111 held → a single timeout pulse, press_valid stays 0. A second run also applies resetn=0 mid-DEBOUNCE → all outputs return to reset values.
